// File: rtl/iter_add_sub_if.sv
// Handshake and operand/result bundle for the chunked adder/subtractor.
// The master issues operations and the slave (the ALU slice) returns results.
interface iter_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             mode;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, mode, cin, x, y,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, mode, cin, x, y,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/iter_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands pass through one CHUNK-bit
// adder slice, LSB chunk first, with registered carry/overflow/zero flags.
module iter_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic         clk,
    input logic         clr,
    iter_add_sub_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   slice;
    logic             last;

    assign last = (cnt == LAST);

    // One chunk of the sum per cycle; res_next is the result with the current chunk merged in.
    always_comb begin
        slice    = {1'b0, a_reg[cnt*CHUNK +: CHUNK]}
                 + {1'b0, b_reg[cnt*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry};
        res_next = res;
        res_next[cnt*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is folded into the operand latch: B is inverted and the carry seeded with 1.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.zero <= 1'b0;
        end else if (accept) begin
            a_reg <= bus.x;
            b_reg <= bus.mode ? ~bus.y : bus.y;
            carry <= bus.mode ? 1'b1 : bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            res   <= res_next;
            carry <= slice[CHUNK];
            if (last) begin
                bus.sum  <= res_next;
                bus.cout <= slice[CHUNK];
                bus.ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                         && (res_next[WIDTH-1] != a_reg[WIDTH-1]);
                bus.zero <= (res_next == '0);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_iter_add_sub.sv
// Directed bench for iter_add_sub at WIDTH=8, CHUNK=2 (four cycles per operation).
module tb_iter_add_sub;
    localparam int WIDTH = 8;
    localparam int CHUNK = 2;

    typedef struct {
        string      name;
        logic [7:0] x;
        logic [7:0] y;
        logic       mode;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    logic clk;
    logic clr;
    int   total;
    int   bad;
    vec_t vecs[8];

    iter_add_sub_if #(.WIDTH(WIDTH)) bus ();

    iter_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse, corrupting the inputs while it runs.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic mode,
                                 input logic cin, output int waited, output int busyCnt,
                                 output int overlap, output logic gotDone);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = x;
        bus.y     = y;
        bus.mode  = mode;
        bus.cin   = cin;
        waited    = 0;
        busyCnt   = 0;
        overlap   = 0;
        gotDone   = 1'b0;
        while (!gotDone && waited < 20) begin
            @(negedge clk);
            waited++;
            if (bus.busy) busyCnt++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) gotDone = 1'b1;
            bus.start = 1'b0;
            bus.x     = ~x;
            bus.y     = x;
            bus.mode  = ~mode;
            bus.cin   = ~cin;
        end
    endtask

    initial begin
        int   waited;
        int   busyCnt;
        int   overlap;
        int   doneCnt;
        int   firstDone;
        int   secondDone;
        logic gotDone;
        logic [7:0] firstSum;

        total = 0;
        bad   = 0;
        vecs[0] = '{"add",        8'd42,  8'd58,  1'b0, 1'b0, 8'h64, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"add_wrap",   8'hFF,  8'h01,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{"add_cin",    8'h7F,  8'h00,  1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"sub_neg",    8'd21,  8'd105, 1'b1, 1'b0, 8'hAC, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"sub_eq",     8'h2A,  8'h2A,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"sub_ovf",    8'h80,  8'h01,  1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{"add_negovf", 8'h80,  8'h80,  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{"sub_cinign", 8'h10,  8'h05,  1'b1, 1'b1, 8'h0B, 1'b1, 1'b0, 1'b0};

        clr       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.cin   = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_sum",  32'(bus.sum),  32'd0);
        checkOutput("reset_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
        clr = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].cin,
                          waited, busyCnt, overlap, gotDone);
            checkOutput({vecs[i].name, "_done"},    32'(gotDone),  32'd1);
            checkOutput({vecs[i].name, "_latency"}, 32'(waited),   32'd5);
            checkOutput({vecs[i].name, "_busy"},    32'(busyCnt),  32'd4);
            checkOutput({vecs[i].name, "_overlap"}, 32'(overlap),  32'd0);
            checkOutput({vecs[i].name, "_sum"},     32'(bus.sum),  32'(vecs[i].sum));
            checkOutput({vecs[i].name, "_flags"}, {29'd0, bus.cout, bus.ovf, bus.zero},
                        {29'd0, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
        end

        // A second start two cycles into 105+21 must be ignored entirely.
        busyCnt = 0;
        doneCnt = 0;
        firstSum = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneCnt++;
                firstSum = bus.sum;
            end
            bus.start = (i == 0) || (i == 2);
            if (i == 0) begin
                bus.x = 8'd105; bus.y = 8'd21; bus.mode = 1'b0; bus.cin = 1'b0;
            end else if (i == 2) begin
                bus.x = 8'd1; bus.y = 8'd1;
            end
        end
        checkOutput("busy_start_done_count", 32'(doneCnt),  32'd1);
        checkOutput("busy_start_busy_count", 32'(busyCnt),  32'd4);
        checkOutput("busy_start_sum",        32'(firstSum), 32'h7E);
        checkOutput("busy_start_hold_sum",   32'(bus.sum),  32'h7E);

        // Start held into DONE chains the next operation with no idle cycle.
        firstDone  = -1;
        secondDone = -1;
        firstSum   = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.done && firstDone < 0) begin
                firstDone = i;
                firstSum  = bus.sum;
            end else if (bus.done && secondDone < 0) begin
                secondDone = i;
            end
            bus.start = (i == 0) || (i == firstDone);
            if (i == 0) begin
                bus.x = 8'd42; bus.y = 8'd58; bus.mode = 1'b0; bus.cin = 1'b0;
            end else if (i == firstDone) begin
                bus.x = 8'd100; bus.y = 8'd58;
            end
            if (secondDone >= 0) break;
        end
        checkOutput("b2b_first_at",  32'(firstDone),  32'd5);
        checkOutput("b2b_first_sum", 32'(firstSum),   32'h64);
        checkOutput("b2b_second_at", 32'(secondDone), 32'd10);
        checkOutput("b2b_sum",       32'(bus.sum),    32'h9E);
        checkOutput("b2b_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'b010);
        @(negedge clk);
        bus.start = 1'b0;

        // clr two cycles into an operation aborts it and clears the held result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.x = 8'd3; bus.y = 8'd4; bus.mode = 1'b0; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        checkOutput("clr_busy", 32'(bus.busy), 32'd0);
        checkOutput("clr_sum",  32'(bus.sum),  32'd0);
        @(negedge clk);
        clr = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) doneCnt++;
        end
        checkOutput("clr_no_done", 32'(doneCnt), 32'd0);
        applyStimulus(8'd42, 8'd58, 1'b0, 1'b0, waited, busyCnt, overlap, gotDone);
        checkOutput("after_clr_done", 32'(gotDone), 32'd1);
        checkOutput("after_clr_sum",  32'(bus.sum), 32'h64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
